// File: rtl/mem_port_pkg.sv
// Shared constants, FSM state type and byte-enable helper for the write-port
// slice of the 32x32 synchronous-read memory.
package mem_port_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_write_port_if.sv
// Write/read/clear bus of mem_write_port. Write handshake: a word transfers on
// a rising clk edge where wr_valid && wr_ready; wr_ready never depends on wr_valid.
interface mem_write_port_if;
    import mem_port_pkg::*;

    logic              clr_start;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [DEPTH-1:0]  used_addr;
    logic [DATA_W-1:0] used_dbits;
    state_e            dbg_state;

    modport master (
        output clr_start, wr_valid, wr_addr, wr_data, wr_be, rd_addr,
        input  wr_ready, rd_data, busy, used_addr, used_dbits, dbg_state
    );

    modport slave (
        input  clr_start, wr_valid, wr_addr, wr_data, wr_be, rd_addr,
        output wr_ready, rd_data, busy, used_addr, used_dbits, dbg_state
    );

endinterface

// File: rtl/mem_array_1r1w.sv
// Storage array: byte-masked write port plus read-first registered read port.
// Deliberately unreset so it maps onto RAM macros.
module mem_array_1r1w #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] wmask_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Non-blocking read of the pre-edge contents gives read-first behaviour.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_write_port.sv
// Write-side controller: clear FSM, write handshake, written-address bitmap and
// written-data OR accumulator, driving a single mem_array_1r1w.
module mem_write_port
    import mem_port_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mem_write_port_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  used_addr_q, used_addr_d;
    logic [DATA_W-1:0] used_dbits_q, used_dbits_d;
    logic              rd_vld_q;

    logic              busy, wr_ready, wr_fire;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata, arr_wmask, arr_rdata, be_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = '0;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (bus.clr_start) state_d = CLEAR;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy      = (state_q == CLEAR);
        wr_ready  = (state_q == IDLE);
        wr_fire   = wr_ready && bus.wr_valid;
        be_mask   = be_to_mask(bus.wr_be);
        arr_we    = busy || wr_fire;
        arr_waddr = busy ? ptr_q : bus.wr_addr;
        arr_wdata = busy ? '0 : bus.wr_data;
        arr_wmask = busy ? '1 : be_mask;
    end

    // Accumulator reset on the entry edge wins over a same-cycle write.
    always_comb begin
        used_addr_d  = used_addr_q;
        used_dbits_d = used_dbits_q;
        if (busy) begin
            used_addr_d[ptr_q] = 1'b0;
        end else if (wr_fire && (bus.wr_be != '0)) begin
            used_addr_d[bus.wr_addr] = 1'b1;
            used_dbits_d = used_dbits_q | (bus.wr_data & be_mask);
        end
        if (wr_ready && bus.clr_start) used_dbits_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_addr_q  <= '0;
            used_dbits_q <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            used_addr_q  <= used_addr_d;
            used_dbits_q <= used_dbits_d;
            rd_vld_q     <= wr_ready;
        end
    end

    mem_array_1r1w #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .wmask_i (arr_wmask),
        .raddr_i (bus.rd_addr),
        .rdata_o (arr_rdata)
    );

    // The unreset array read register is hidden until a read taken in IDLE lands.
    assign bus.rd_data    = rd_vld_q ? arr_rdata : '0;
    assign bus.wr_ready   = wr_ready;
    assign bus.busy       = busy;
    assign bus.used_addr  = used_addr_q;
    assign bus.used_dbits = used_dbits_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mem_write_port.sv
// Self-checking bench for mem_write_port: behavioural model feeds an expected
// read-data queue; every comparison goes through check().
module tb_mem_write_port;
  import mem_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_write_port_if bus();

  mem_write_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_busy;
  int                m_ptr;
  logic [DEPTH-1:0]  m_used;
  logic [DATA_W-1:0] m_dbits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    bus.clr_start = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_be     = '0;
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [BE_W-1:0] be);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_be    = be;
  endtask

  // Model of one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [DATA_W-1:0] mask;
    exp_q.push_back(m_busy ? '0 : m_mem[bus.rd_addr]);
    if (m_busy) begin
      m_mem[m_ptr]  = '0;
      m_used[m_ptr] = 1'b0;
      if (m_ptr == DEPTH - 1) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      if (bus.wr_valid) begin
        mask = '0;
        for (int b = 0; b < BE_W; b++) if (bus.wr_be[b]) mask[8*b +: 8] = 8'hFF;
        m_mem[bus.wr_addr] = (m_mem[bus.wr_addr] & ~mask) | (bus.wr_data & mask);
        if (bus.wr_be != '0) begin
          m_used[bus.wr_addr] = 1'b1;
          m_dbits = m_dbits | (bus.wr_data & mask);
        end
      end
      if (bus.clr_start) begin
        m_busy  = 1'b1;
        m_dbits = '0;
      end
    end
  endtask

  task automatic cycle();
    logic [DATA_W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rd_data", bus.rd_data, e);
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("wr_ready", 32'(bus.wr_ready), 32'(!m_busy));
    check("used_addr", bus.used_addr, m_used);
    check("used_dbits", bus.used_dbits, m_dbits);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #3;
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_used_addr", bus.used_addr, 32'h0);
    check("rst_used_dbits", bus.used_dbits, 32'h0);
    m_busy  = 1'b1;
    m_ptr   = 0;
    m_used  = '0;
    m_dbits = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Counts edges until busy drops; optionally pulses clr_start at iteration kick_at.
  task automatic run_clear(input string tag, input int kick_at);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      bus.clr_start = (i == kick_at);
      cycle();
      n++;
      if (!bus.busy) break;
    end
    bus.clr_start = 1'b0;
    check(tag, 32'(n), 32'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    bus.rd_addr = '0;
    idle_in();
    rst_n = 1'b0;
    #2;

    // Reset release and full clear, then sweep every address.
    do_reset();
    run_clear("clear_len_reset", -1);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = ADDR_W'(a);
      cycle();
    end
    check("used_after_reset", bus.used_addr, 32'h0);

    // Full-word write then read back.
    drive_write(5'd5, 32'hDEADBEEF, 4'hF);
    bus.rd_addr = '0;
    cycle();
    idle_in();
    bus.rd_addr = 5'd5;
    cycle();
    check("wr5_rd", bus.rd_data, 32'hDEADBEEF);
    check("wr5_used", bus.used_addr, 32'h20);
    check("wr5_dbits", bus.used_dbits, 32'hDEADBEEF);

    // Byte-masked merge, then a be=0 no-op write.
    drive_write(5'd7, 32'hFFFFFFFF, 4'hF);
    cycle();
    drive_write(5'd7, 32'h11223344, 4'b0101);
    cycle();
    idle_in();
    bus.rd_addr = 5'd7;
    cycle();
    check("be_merge", bus.rd_data, 32'hFF22FF44);
    drive_write(5'd9, 32'h12345678, 4'h0);
    cycle();
    idle_in();
    bus.rd_addr = 5'd9;
    cycle();
    check("be0_used9", 32'(bus.used_addr[9]), 32'd0);
    check("be0_rd9", bus.rd_data, 32'h0);

    // Read-first on a same-cycle write.
    drive_write(5'd3, 32'hA5A5A5A5, 4'hF);
    bus.rd_addr = 5'd3;
    cycle();
    check("rf_old", bus.rd_data, 32'h0);
    idle_in();
    cycle();
    check("rf_new", bus.rd_data, 32'hA5A5A5A5);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.wr_data  = $urandom();
      bus.wr_be    = BE_W'($urandom_range(0, 15));
      bus.rd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle_in();

    // clr_start with a same-cycle write; second clr_start mid-clear is ignored.
    drive_write(5'd1, 32'h0000BEEF, 4'hF);
    bus.clr_start = 1'b1;
    cycle();
    idle_in();
    run_clear("clear_len_kick", 5);
    bus.rd_addr = 5'd1;
    cycle();
    check("clr_rd1", bus.rd_data, 32'h0);
    check("clr_used", bus.used_addr, 32'h0);
    check("clr_dbits", bus.used_dbits, 32'h0);

    // Reset in the middle of a clear restarts it from the beginning.
    drive_write(5'd4, 32'h01020304, 4'hF);
    cycle();
    idle_in();
    bus.clr_start = 1'b1;
    cycle();
    bus.clr_start = 1'b0;
    repeat (10) cycle();
    do_reset();
    run_clear("clear_len_rerst", -1);
    bus.rd_addr = 5'd4;
    cycle();
    check("rerst_rd4", bus.rd_data, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_write_port.md
# mem_write_port

Write-side companion to the 32x32 synchronous-read memory: owns the storage array, accepts byte-enabled writes over a valid/ready handshake, and serves the registered read port. After reset, and on request, it runs a one-entry-per-cycle clear sequence. It also keeps a bitmap of written addresses and an OR-accumulator of written data bits, so formal and simulation benches can constrain and check reads.

## Interface
- DEPTH, 32, number of words; power of two
- ADDR_W, 5, address width, equal to log2(DEPTH)
- DATA_W, 32, word width; multiple of 8
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- clr_start  in  1  single-cycle pulse requesting a full clear
- wr_valid  in  1  write request valid
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i]
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- busy  out  1  clear sequence in progress
- used_addr  out  DEPTH  bit a set when address a holds written data
- used_dbits  out  DATA_W  OR of all byte-masked data written since the last clear

## Operation
- FSM states: CLEAR, IDLE.
- rst_n low forces:
  - state=CLEAR, clear pointer=0.
  - rd_data=0, used_addr=0, used_dbits=0.
  - busy=1, wr_ready=0.
- The array itself has no reset; the CLEAR state zeroes it.
- CLEAR:
  - Each cycle, writes 0 to mem[ptr] and clears used_addr[ptr], then increments ptr.
  - At ptr==DEPTH-1, after that cycle's write, goes to IDLE and ptr returns to 0.
  - used_dbits clears on entry to CLEAR.
- IDLE:
  - wr_ready=1; busy=0.
  - An accepted write updates only the enabled bytes of mem[wr_addr].
  - If wr_be!=0, it also sets used_addr[wr_addr] and ORs (wr_data & byte mask) into used_dbits.
  - wr_be==0: the write is accepted as a no-op; no bitmap or accumulator change.
- clr_start in IDLE moves the FSM to CLEAR on the next edge. clr_start in CLEAR is ignored; the clear does not restart.
- clr_start and an accepted write in the same IDLE cycle: the write commits, then CLEAR begins and erases it.
- Read port:
  - rd_data <= mem[rd_addr] every cycle in IDLE.
  - Read-first: a same-cycle write to rd_addr returns the old contents.
  - While busy=1, rd_data <= 0 regardless of array contents.
- Reset asserted mid-clear or mid-write: the operation is abandoned and the clear restarts from ptr=0 after release.

## Timing
- Read latency is 1 cycle: rd_addr sampled at edge N, rd_data valid after edge N.
- Write latency is 1 cycle: a write accepted at edge N is visible to a read sampled at edge N+1.
- wr_ready and busy are registered state decodes, with no combinational path from any input.
- Clear duration is exactly DEPTH cycles: busy=1 for 32 edges after rst_n release, or after the edge that samples clr_start.
- used_addr and used_dbits are registered and update on the same edge as the array write.

## Structure
- Package mem_port_pkg holds:
  - DEPTH, ADDR_W, DATA_W constants.
  - The state enum {CLEAR, IDLE}.
  - A function expanding wr_be into a DATA_W bit mask.
- One sub-module, mem_array_1r1w: the storage array, with a byte-masked write port and a read-first registered read port, no reset.
- The FSM, clear pointer, bitmap and accumulator live in mem_write_port and drive the array.

## Test plan
- Reset release, then read every address -> busy=1 for 32 cycles, wr_ready=0 throughout, then all reads return 0 and used_addr=0.
- Write 0xDEADBEEF, be=4'hF, to addr 5; read addr 5 next cycle -> rd_data=0xDEADBEEF, used_addr=32'h20, used_dbits=0xDEADBEEF.
- Write 0x11223344, be=4'b0101, over 0xFFFFFFFF at addr 7 -> rd_data=0xFF22FF44; be=0 to addr 9 -> used_addr[9] stays 0.
- Same-cycle write 0xA5A5A5A5 and read of addr 3 (old value 0) -> rd_data=0 that cycle, 0xA5A5A5A5 the next.
- clr_start together with a write to addr 1 -> write commits, busy=1 for 32 cycles, then addr 1 reads 0 and used_addr=0, used_dbits=0; a second clr_start mid-clear does not extend busy.
- rst_n pulsed low at clear cycle 10 -> outputs return to reset values, and the clear reruns the full 32 cycles after release.
